// File: rtl/clif_sched_pkg.sv
// Shared types and constants for the CLIF neuron update scheduler.
package clif_sched_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4,
    FIN  = 3'd5
  } sched_state_t;

  localparam logic NEURON_TYPE_EX = 1'b0;
  localparam logic NEURON_TYPE_IN = 1'b1;

endpackage

// File: rtl/clif_sched_addr_counter.sv
// Neuron index register for the scheduler sweep.
// load clears the index and captures the neuron count for this sweep.
// inc advances the index. The index never moves past count-1.
// last flags the final neuron of the sweep.
module clif_sched_addr_counter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] idx,
  output logic [ADDR_WIDTH:0]   idx_next,
  output logic                  last
);

  logic [ADDR_WIDTH:0] count_q;

  assign idx_next = {1'b0, idx} + (ADDR_WIDTH+1)'(1);
  assign last     = (idx_next == count_q);

  // Index and sweep length; increment is blocked at the last neuron so it cannot wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      count_q <= '0;
    end else if (load) begin
      idx     <= '0;
      count_q <= count;
    end else if (inc && !last) begin
      idx     <= idx_next[ADDR_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/clif_neuron_update_scheduler.sv
// Sweeps one conductance LIF unit across up to NUM_NEURONS virtual neurons per timestep.
// Each neuron goes through RD -> WAIT (RAM_RD_LAT cycles) -> EXEC -> WB.
// Optional feature macro: CLIF_SCHED_SPIKE_COUNT_EN adds the SpikeCount output.
//
// state | meaning
// IDLE  | waiting for Start
// RD    | read strobe for the current neuron
// WAIT  | RAM read latency; data valid at the end of the last WAIT cycle
// EXEC  | unit update enable for the current neuron
// WB    | write-back, weight-sum clear, spike event
// FIN   | Done pulse, last Busy cycle
module clif_neuron_update_scheduler
  import clif_sched_pkg::*;
#(
  parameter int NUM_NEURONS = 256,
  parameter int NUM_EX      = 128,
  parameter int ADDR_WIDTH  = 8,
  parameter int RAM_RD_LAT  = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   NumActive,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Overrun,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] RdAddr,
  output logic                  WrEn,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  output logic                  UnitUpdateEnable,
  output logic                  UnitNeuronType,
  input  logic                  UnitSpike,
  output logic                  SpikeValid,
  output logic [ADDR_WIDTH-1:0] SpikeAddr
`ifdef CLIF_SCHED_SPIKE_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   SpikeCount
`endif
);

  localparam logic [ADDR_WIDTH:0] NUM_NEURONS_W = NUM_NEURONS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] NUM_EX_W      = NUM_EX[ADDR_WIDTH:0];

  sched_state_t state;
  logic [1:0] wait_cnt;

  logic [ADDR_WIDTH:0]   n_clamp;
  logic                  start_sweep;
  logic                  idx_inc;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH:0]   idx_next;
  logic                  idx_last;

  function automatic logic type_of(input logic [ADDR_WIDTH:0] i);
    return (i >= NUM_EX_W) ? NEURON_TYPE_IN : NEURON_TYPE_EX;
  endfunction

  assign n_clamp     = (NumActive > NUM_NEURONS_W) ? NUM_NEURONS_W : NumActive;
  assign start_sweep = (state == IDLE) && Start && (NumActive != '0);
  assign idx_inc     = (state == WB) && !idx_last;

  clif_sched_addr_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_counter (
    .clk      (Clock),
    .rst      (Reset),
    .load     (start_sweep),
    .count    (n_clamp),
    .inc      (idx_inc),
    .idx      (idx),
    .idx_next (idx_next),
    .last     (idx_last)
  );

  // Addresses are only driven while their strobe is active
  assign RdAddr     = RdEn ? idx : '0;
  assign WrAddr     = WrEn ? idx : '0;
  // The unit's spike output is valid during write-back, so the event is qualified by WrEn
  assign SpikeValid = WrEn && UnitSpike;
  assign SpikeAddr  = SpikeValid ? idx : '0;

  // Sweep FSM with registered strobes; each strobe is set on entry to its state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      Busy             <= 1'b0;
      Done             <= 1'b0;
      Overrun          <= 1'b0;
      RdEn             <= 1'b0;
      WrEn             <= 1'b0;
      UnitUpdateEnable <= 1'b0;
      UnitNeuronType   <= NEURON_TYPE_EX;
    end else begin
      Done             <= 1'b0;
      RdEn             <= 1'b0;
      WrEn             <= 1'b0;
      UnitUpdateEnable <= 1'b0;
      if (Start && (state != IDLE)) begin
        Overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (Start) begin
            Busy <= 1'b1;
            if (NumActive != '0) begin
              state          <= RD;
              RdEn           <= 1'b1;
              UnitNeuronType <= type_of('0);
            end else begin
              state <= FIN;
              Done  <= 1'b1;
            end
          end
        end
        RD: begin
          state    <= WAIT;
          wait_cnt <= 2'(RAM_RD_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state            <= EXEC;
            UnitUpdateEnable <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        EXEC: begin
          state <= WB;
          WrEn  <= 1'b1;
        end
        WB: begin
          if (idx_last) begin
            state          <= FIN;
            Done           <= 1'b1;
            UnitNeuronType <= NEURON_TYPE_EX;
          end else begin
            state          <= RD;
            RdEn           <= 1'b1;
            UnitNeuronType <= type_of(idx_next);
          end
        end
        FIN: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLIF_SCHED_SPIKE_COUNT_EN
  // Spike counter: cleared by an accepted Start, holds after Done until the next Start
  always_ff @(posedge Clock) begin
    if (Reset) begin
      SpikeCount <= '0;
    end else if ((state == IDLE) && Start) begin
      SpikeCount <= '0;
    end else if (SpikeValid) begin
      SpikeCount <= SpikeCount + (ADDR_WIDTH+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_clif_neuron_update_scheduler.sv
// Self-checking bench for clif_neuron_update_scheduler.
// Optional feature macro: CLIF_SCHED_SPIKE_COUNT_EN (SpikeCount checks).
module tb_clif_neuron_update_scheduler;

  localparam int NN  = 256;
  localparam int NEX = 2;
  localparam int AW  = 8;
  localparam int LAT = 1;
  localparam int CPN = 3 + LAT;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_active;
  logic          busy, done, overrun;
  logic          rd_en, wr_en, upd, ntype;
  logic [AW-1:0] rd_addr, wr_addr, spike_addr;
  logic          unit_spike;
  logic          spike_valid;
`ifdef CLIF_SCHED_SPIKE_COUNT_EN
  logic [AW:0]   spike_count;
`endif

  clif_neuron_update_scheduler #(
    .NUM_NEURONS(NN),
    .NUM_EX     (NEX),
    .ADDR_WIDTH (AW),
    .RAM_RD_LAT (LAT)
  ) dut (
    .Clock           (clk),
    .Reset           (rst),
    .Start           (start),
    .NumActive       (num_active),
    .Busy            (busy),
    .Done            (done),
    .Overrun         (overrun),
    .RdEn            (rd_en),
    .RdAddr          (rd_addr),
    .WrEn            (wr_en),
    .WrAddr          (wr_addr),
    .UnitUpdateEnable(upd),
    .UnitNeuronType  (ntype),
    .UnitSpike       (unit_spike),
    .SpikeValid      (spike_valid),
    .SpikeAddr       (spike_addr)
`ifdef CLIF_SCHED_SPIKE_COUNT_EN
    ,
    .SpikeCount      (spike_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  bit spike_mask [NN];
  bit chk_en = 1'b0;

  // behavioural model: sweep in progress, cycle number within the sweep, sweep length
  bit m_act = 1'b0;
  bit m_ovr = 1'b0;
  int m_k   = 0;
  int m_n   = 0;
  int m_len = 0;

  int mon_rd, mon_wr, mon_done, mon_last_wr;
  int spk_q[$];
  int type_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    bit in_nrn, e_rd, e_wr, e_upd, e_done, e_spk;
    int j, ph;
    j  = 0;
    ph = 0;
    in_nrn = m_act && (m_n > 0) && (m_k < m_len);
    if (in_nrn) begin
      j  = (m_k - 1) / CPN;
      ph = (m_k - 1) % CPN;
    end
    e_rd   = in_nrn && (ph == 0);
    e_upd  = in_nrn && (ph == CPN - 2);
    e_wr   = in_nrn && (ph == CPN - 1);
    e_done = m_act && (m_k == m_len);
    e_spk  = e_wr && spike_mask[j];
    chk("busy", busy, m_act);
    chk("done", done, e_done);
    chk("overrun", overrun, m_ovr);
    chk("rd_en", rd_en, e_rd);
    chk("wr_en", wr_en, e_wr);
    chk("update_enable", upd, e_upd);
    chk("spike_valid", spike_valid, e_spk);
    if (e_rd)   chk("rd_addr", rd_addr, j);
    if (e_wr)   chk("wr_addr", wr_addr, j);
    if (e_spk)  chk("spike_addr", spike_addr, j);
    if (in_nrn) chk("neuron_type", ntype, (j >= NEX));
  endtask

  // model update at each active edge, comparison and event monitor on the falling edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_act = 1'b0;
        m_ovr = 1'b0;
      end else if (m_act) begin
        if (start) m_ovr = 1'b1;
        if (m_k == m_len) m_act = 1'b0;
        else m_k++;
      end else if (start) begin
        m_n   = (num_active > NN) ? NN : int'(num_active);
        m_len = (m_n == 0) ? 1 : CPN * m_n + 1;
        m_k   = 1;
        m_act = 1'b1;
      end
      @(negedge clk);
      if (chk_en) begin
        compare_cycle();
        if (rd_en === 1'b1) mon_rd++;
        if (wr_en === 1'b1) begin
          mon_wr++;
          mon_last_wr = int'(wr_addr);
        end
        if (done === 1'b1) mon_done++;
        if (spike_valid === 1'b1) spk_q.push_back(int'(spike_addr));
        if (upd === 1'b1) type_q.push_back(int'(ntype));
      end
    end
  end

  // neuron unit stand-in: registers a spike for the neuron that was last read
  initial begin
    int  last_rd;
    bit  upd_seen, rd_seen;
    int  addr_seen;
    last_rd    = 0;
    unit_spike = 1'b0;
    forever begin
      @(posedge clk);
      upd_seen  = (upd === 1'b1);
      rd_seen   = (rd_en === 1'b1);
      addr_seen = int'(rd_addr);
      #1;
      if (upd_seen) unit_spike = spike_mask[last_rd];
      if (rd_seen) last_rd = addr_seen;
    end
  end

  task automatic pulse_start(input int n);
    logic [31:0] nv;
    nv = n;
    mon_rd = 0;
    mon_wr = 0;
    mon_done = 0;
    mon_last_wr = -1;
    spk_q.delete();
    type_q.delete();
    num_active = nv[AW:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input int first, output int cyc);
    cyc = first;
    while (done !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none expected=done within %0d cycles", limit);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    num_active = '0;
    for (int i = 0; i < NN; i++) spike_mask[i] = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_ntype", ntype, 0);
`ifdef CLIF_SCHED_SPIKE_COUNT_EN
    chk("reset_spike_count", spike_count, 0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1) and 2): four-neuron sweep
    pulse_start(4);
    wait_done(40, 1, cyc);
    chk("t1_latency", cyc, 17);
    @(negedge clk);
    chk("t1_rd_count", mon_rd, 4);
    chk("t1_wr_count", mon_wr, 4);
    chk("t1_last_wr", mon_last_wr, 3);
    chk("t2_type_count", type_q.size(), 4);
    if (type_q.size() == 4) begin
      chk("t2_type0", type_q[0], 0);
      chk("t2_type1", type_q[1], 0);
      chk("t2_type2", type_q[2], 1);
      chk("t2_type3", type_q[3], 1);
    end
    repeat (2) @(negedge clk);

    // 3) spikes on neurons 1 and 3
    spike_mask[1] = 1'b1;
    spike_mask[3] = 1'b1;
    pulse_start(4);
    wait_done(40, 1, cyc);
    chk("t3_latency", cyc, 17);
`ifdef CLIF_SCHED_SPIKE_COUNT_EN
    chk("t3_spike_count", spike_count, 2);
`endif
    @(negedge clk);
    chk("t3_spike_events", spk_q.size(), 2);
    if (spk_q.size() == 2) begin
      chk("t3_spike_addr0", spk_q[0], 1);
      chk("t3_spike_addr1", spk_q[1], 3);
    end
    spike_mask[1] = 1'b0;
    spike_mask[3] = 1'b0;
    repeat (2) @(negedge clk);

    // 4) second Start three cycles into a sweep
    pulse_start(4);
    repeat (2) @(negedge clk);
    num_active = 9'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_overrun_set", overrun, 1);
    wait_done(40, 4, cyc);
    chk("t4_latency", cyc, 17);
    repeat (3) @(negedge clk);
    chk("t4_done_count", mon_done, 1);
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_wr_count", mon_wr, 4);

    // 5) reset during EXEC of neuron 2
    pulse_start(4);
    repeat (10) @(negedge clk);
    chk("t5_in_exec", upd, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_wr_en", wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_rd_en", rd_en, 0);
    chk("t5_overrun", overrun, 0);
    chk("t5_update_enable", upd, 0);
    chk("t5_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(4);
    chk("t5_restart_rd_en", rd_en, 1);
    chk("t5_restart_rd_addr", rd_addr, 0);
    wait_done(40, 1, cyc);
    chk("t5_latency", cyc, 17);
    repeat (2) @(negedge clk);

    // 6) empty sweep, then clamped sweep
    pulse_start(0);
    chk("t6_empty_busy", busy, 1);
    wait_done(10, 1, cyc);
    chk("t6_empty_latency", cyc, 1);
    @(negedge clk);
    chk("t6_empty_busy_drop", busy, 0);
    chk("t6_empty_rd_count", mon_rd, 0);
    repeat (2) @(negedge clk);
    pulse_start(300);
    wait_done(1100, 1, cyc);
    chk("t6_clamp_latency", cyc, 1025);
    @(negedge clk);
    chk("t6_clamp_wr_count", mon_wr, 256);
    chk("t6_clamp_last_wr", mon_last_wr, 255);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
